// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: 2-flop synchronizer, per-channel qualify FSM, level + press/release strobes.
// Optional long-press strobe (hold_p) is built when MULTI_DEBOUNCER_HOLD_EN is defined.
module multi_debouncer #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DB_CYCLES   = 1000,
  parameter int unsigned HOLD_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] btn_db,
  output logic [CHANNELS-1:0] press_p,
  output logic [CHANNELS-1:0] release_p,
  output logic [CHANNELS-1:0] hold_p,
  output logic                any_press
);

  localparam int unsigned MAX_CYC = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;

  logic [CHANNELS-1:0] s1, s2;
  logic [CHANNELS-1:0] press_n;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1        <= '0;
      s2        <= '0;
      any_press <= 1'b0;
    end else begin
      s1        <= btn;
      s2        <= s1;
      any_press <= |press_n;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          db_q, db_n;
    logic          press_q, press_c;
    logic          rel_q, rel_c;

    always_comb begin
      state_n = state;
      cnt_n   = '0;
      db_n    = db_q;
      press_c = 1'b0;
      rel_c   = 1'b0;
      case (state)
        LOW: begin
          db_n = 1'b0;
          if (s2[i]) state_n = RISE_CHK;
        end
        RISE_CHK: begin
          if (!s2[i]) begin
            state_n = LOW;
          end else if (cnt == DB_LAST) begin
            state_n = HIGH;
            db_n    = 1'b1;
            press_c = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HIGH: begin
          db_n = 1'b1;
          if (!s2[i]) state_n = FALL_CHK;
        end
        FALL_CHK: begin
          if (s2[i]) begin
            state_n = HIGH;
          end else if (cnt == DB_LAST) begin
            state_n = LOW;
            db_n    = 1'b0;
            rel_c   = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = LOW;
          db_n    = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        state   <= LOW;
        cnt     <= '0;
        db_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_n;
        cnt     <= cnt_n;
        db_q    <= db_n;
        press_q <= press_c;
        rel_q   <= rel_c;
      end
    end

    assign press_n[i]   = press_c;
    assign btn_db[i]    = db_q;
    assign press_p[i]   = press_q;
    assign release_p[i] = rel_q;

`ifdef MULTI_DEBOUNCER_HOLD_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_CYCLES);

    logic [CW-1:0] hcnt, hcnt_n;
    logic          hold_q, hold_c;

    // Only a fresh press (RISE_CHK->HIGH) restarts the count, so a rejected
    // release glitch does not produce a second hold pulse. Counting to HOLD_SAT
    // (one past the threshold) makes the pulse fire exactly once; a confirmed
    // release on the threshold cycle wins over hold.
    always_comb begin
      hcnt_n = hcnt;
      hold_c = 1'b0;
      if (state == RISE_CHK && state_n == HIGH) begin
        hcnt_n = '0;
      end else if (state_n == LOW) begin
        hcnt_n = '0;
      end else if (state == HIGH || state == FALL_CHK) begin
        if (hcnt < HOLD_SAT) begin
          hcnt_n = hcnt + 1'b1;
          hold_c = (hcnt == HOLD_LAST);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        hcnt   <= '0;
        hold_q <= 1'b0;
      end else begin
        hcnt   <= hcnt_n;
        hold_q <= hold_c;
      end
    end

    assign hold_p[i] = hold_q;
`else
    assign hold_p[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: run-length reference model checked every cycle, plus literal
// expectations at hand-computed edges (DB_CYCLES=4, HOLD_CYCLES=10, CHANNELS=4).
module tb_multi_debouncer;

  localparam int CH   = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;
`ifdef MULTI_DEBOUNCER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_l;
  logic [CH-1:0] btn;
  logic [CH-1:0] btn_db, press_p, release_p, hold_p;
  logic          any_press;

  multi_debouncer #(
    .CHANNELS   (CH),
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .btn      (btn),
    .btn_db   (btn_db),
    .press_p  (press_p),
    .release_p(release_p),
    .hold_p   (hold_p),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
  endfunction

  // Reference model: a channel flips once the synchronized input has disagreed
  // with the debounced level for DB+1 consecutive samples.
  bit      d1 [CH];
  bit      d2 [CH];
  bit      m_db [CH];
  int      run [CH];
  int      age [CH];
  logic [CH-1:0] e_db = '0, e_press = '0, e_rel = '0, e_hold = '0;
  logic          e_any = 1'b0;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < CH; i++) begin
        d1[i] = 0; d2[i] = 0; m_db[i] = 0; run[i] = 0; age[i] = 0;
      end
      e_db = '0; e_press = '0; e_rel = '0; e_hold = '0; e_any = 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit seen, was, flip;
        seen  = d2[i];
        d2[i] = d1[i];
        d1[i] = btn[i];
        was   = m_db[i];
        e_press[i] = 1'b0; e_rel[i] = 1'b0; e_hold[i] = 1'b0;
        if (seen != m_db[i]) run[i]++;
        else run[i] = 0;
        flip = (run[i] == DB + 1);
        if (flip) begin
          run[i]  = 0;
          m_db[i] = seen;
          if (seen) begin e_press[i] = 1'b1; age[i] = 0; end
          else e_rel[i] = 1'b1;
        end else if (was) begin
          age[i]++;
          if (HOLD_EN && age[i] == HOLD) e_hold[i] = 1'b1;
        end
        e_db[i] = m_db[i];
      end
      e_any = |e_press;
    end
  end

  always @(negedge clk) begin
    chk("cyc_btn_db",    btn_db,    e_db);
    chk("cyc_press_p",   press_p,   e_press);
    chk("cyc_release_p", release_p, e_rel);
    chk("cyc_hold_p",    hold_p,    e_hold);
    chk("cyc_any_press", any_press, e_any);
  end

  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    rst_l = 1'b1;
    btn   = '0;
    #1 rst_l = 1'b0;

    at_edge(2);
    chk("rst_btn_db",    btn_db,    4'b0000);
    chk("rst_press_p",   press_p,   4'b0000);
    chk("rst_release_p", release_p, 4'b0000);
    chk("rst_any_press", any_press, 1'b0);
    at_edge(3);  rst_l = 1'b1;

    // clean press on ch0, first high sample at edge 10
    at_edge(9);  btn[0] = 1'b1;
    at_edge(15); chk("press0_before", btn_db, 4'b0000);
    at_edge(16);
    chk("press0_db",  btn_db,    4'b0001);
    chk("press0_p",   press_p,   4'b0001);
    chk("press0_any", any_press, 1'b1);
    at_edge(17);
    chk("press0_p_off",   press_p,   4'b0000);
    chk("press0_any_off", any_press, 1'b0);

    // bounce on ch1: 3 high samples, 1 low, then high from edge 24
    at_edge(19); btn[1] = 1'b1;
    at_edge(22); btn[1] = 1'b0;
    at_edge(23); btn[1] = 1'b1;
    at_edge(26); chk("hold0", hold_p, HOLD_EN ? 4'b0001 : 4'b0000);
    at_edge(27); chk("hold0_off", hold_p, 4'b0000);
    at_edge(29); chk("bounce1_before", btn_db, 4'b0001);
    at_edge(30);
    chk("bounce1_db", btn_db,  4'b0011);
    chk("bounce1_p",  press_p, 4'b0010);

    // ch2: press, 2-sample low glitch, then real release from edge 52
    at_edge(31); btn[2] = 1'b1;
    at_edge(40); chk("hold1", hold_p, HOLD_EN ? 4'b0010 : 4'b0000);
    at_edge(41); btn[2] = 1'b0;
    at_edge(43); btn[2] = 1'b1;
    at_edge(48); chk("hold2", hold_p, HOLD_EN ? 4'b0100 : 4'b0000);
    at_edge(50);
    chk("glitch2_db",  btn_db,    4'b0111);
    chk("glitch2_rel", release_p, 4'b0000);
    at_edge(51); btn[2] = 1'b0;
    at_edge(57); chk("rel2_before", btn_db, 4'b0111);
    at_edge(58);
    chk("rel2_db",  btn_db,    4'b0011);
    chk("rel2_p",   release_p, 4'b0100);
    at_edge(59); chk("rel2_p_off", release_p, 4'b0000);

    // release ch0/ch1, then all four together
    at_edge(60); btn = 4'b0000;
    at_edge(67); chk("rel01_p", release_p, 4'b0011);
    at_edge(70); btn = 4'b1111;
    at_edge(77);
    chk("sim_press", press_p,   4'b1111);
    chk("sim_any",   any_press, 1'b1);
    at_edge(78);
    chk("sim_press_off", press_p,   4'b0000);
    chk("sim_any_off",   any_press, 1'b0);
    chk("sim_db",        btn_db,    4'b1111);

    // reset while ch0 qualifies and ch3 is debounced high
    at_edge(80); btn = 4'b1000;
    at_edge(90); btn = 4'b1001;
    at_edge(94); rst_l = 1'b0;
    #1;
    chk("midrst_db",   btn_db,  4'b0000);
    chk("midrst_p",    press_p, 4'b0000);
    at_edge(96); rst_l = 1'b1;
    at_edge(102); chk("postrst_before", press_p, 4'b0000);
    at_edge(103);
    chk("postrst_p",   press_p,   4'b1001);
    chk("postrst_any", any_press, 1'b1);
    at_edge(104); chk("postrst_p_off", press_p, 4'b0000);
    at_edge(113); chk("hold_postrst", hold_p, HOLD_EN ? 4'b1001 : 4'b0000);
    at_edge(120);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
